// File: rtl/seq_divider_pkg.sv
// Shared width constants and FSM state type for the sequential restoring divider.
package seq_divider_pkg;

  localparam int N     = 4;
  localparam int QW    = 2 * N;
  localparam int CNT_W = $clog2(2 * N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step count loaded on accept; the counter runs down to zero inclusive.
  function automatic logic [CNT_W-1:0] last_step();
    return CNT_W'(2 * N - 1);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used by the ripple subtractor.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/seq_divider_div_step.sv
// Combinational restoring-division step: shift in one dividend bit, trial-subtract
// the divisor with a ripple of full adders, and keep the difference if no borrow.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int W = N
) (
  input  logic [W-1:0] r,
  input  logic         q_msb,
  input  logic [W-1:0] d,
  output logic [W:0]   r_nxt,
  output logic         q_bit
);

  logic [W:0]   t;
  logic [W:0]   d_inv;
  logic [W:0]   diff;
  logic [W+1:0] carry;

  assign t        = {r, q_msb};
  assign d_inv    = ~{1'b0, d};
  assign carry[0] = 1'b1;

  // T + ~D + 1: a carry out of the top cell means no borrow, i.e. T >= D.
  for (genvar i = 0; i <= W; i++) begin : g_sub
    full_adder u_fa (
      .a  (t[i]),
      .b  (d_inv[i]),
      .ci (carry[i]),
      .s  (diff[i]),
      .co (carry[i+1])
    );
  end

  assign q_bit = carry[W+1];
  assign r_nxt = q_bit ? diff : t;

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on both sides.
module seq_divider
  import seq_divider_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [QW-1:0] dividend,
  input  logic [N-1:0]  divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] quotient,
  output logic [N-1:0]  remainder,
  output logic          div_zero
);

  state_t           state;
  logic [QW-1:0]    q;
  logic [N-1:0]     d;
  logic [N:0]       r;
  logic [CNT_W-1:0] cnt;

  logic [N:0]       r_nxt;
  logic             q_bit;
  logic             r_msb_unused;

  div_step #(.W(N)) u_step (
    .r     (r[N-1:0]),
    .q_msb (q[QW-1]),
    .d     (d),
    .r_nxt (r_nxt),
    .q_bit (q_bit)
  );

  // R[N] only guards the intermediate shift; it is always zero once a step settles.
  assign r_msb_unused = r[N];

  assign quotient  = q;
  assign remainder = r[N-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      div_zero  <= 1'b0;
      q         <= '0;
      d         <= '0;
      r         <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            d        <= divisor;
            r        <= '0;
            cnt      <= last_step();
            in_ready <= 1'b0;
            if (divisor == '0) begin
              q         <= '1;
              div_zero  <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              q        <= dividend;
              div_zero <= 1'b0;
              state    <= RUN;
            end
          end
        end
        RUN: begin
          r <= r_nxt;
          q <= {q[QW-2:0], q_bit};
          if (cnt == '0) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          // Results hold here until the consumer takes them.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive checks of seq_divider for N=4.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_zero;

  int n_cmp = 0;
  int n_err = 0;

  seq_divider dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands once in_ready is seen; returns ok=0 if it never comes.
  task automatic accept(input logic [7:0] a, input logic [3:0] b, output bit ok);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    ok = in_ready;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, quotient, remainder, div_zero} !== {1'b1, 1'b0, 8'd0, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset: in_ready=%b out_valid=%b q=%0d r=%0d dz=%b, required 1 0 0 0 0",
               in_ready, out_valid, quotient, remainder, div_zero);
    end
  endtask

  task automatic test_basic();
    logic [7:0] a_t [6] = '{8'd200, 8'd255, 8'd0, 8'd15, 8'd255, 8'd17};
    logic [3:0] b_t [6] = '{4'd7,   4'd1,   4'd5, 4'd15, 4'd15,  4'd3};
    logic [7:0] q_t [6] = '{8'd28,  8'd255, 8'd0, 8'd1,  8'd17,  8'd5};
    logic [3:0] r_t [6] = '{4'd4,   4'd0,   4'd0, 4'd0,  4'd0,   4'd2};
    int cyc;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      accept(a_t[i], b_t[i], ok);
      wait_done(cyc);
      n_cmp++;
      if (!ok || cyc !== 8) begin
        n_err++;
        $display("FAIL basic_latency %0d/%0d: cycles=%0d ok=%0b, required 8", a_t[i], b_t[i], cyc, ok);
      end
      n_cmp++;
      if ({quotient, remainder, div_zero} !== {q_t[i], r_t[i], 1'b0}) begin
        n_err++;
        $display("FAIL basic %0d/%0d: q=%0d r=%0d dz=%b, required q=%0d r=%0d dz=0",
                 a_t[i], b_t[i], quotient, remainder, div_zero, q_t[i], r_t[i]);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_cmp++;
      if ({in_ready, out_valid} !== 2'b10) begin
        n_err++;
        $display("FAIL basic_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
      end
    end
  endtask

  task automatic test_div_zero();
    int cyc;
    bit ok;
    accept(8'd9, 4'd0, ok);
    wait_done(cyc);
    n_cmp++;
    if (!ok || cyc !== 0) begin
      n_err++;
      $display("FAIL div_zero_latency: cycles=%0d ok=%0b, required 0", cyc, ok);
    end
    n_cmp++;
    if ({quotient, remainder, div_zero} !== {8'hFF, 4'd0, 1'b1}) begin
      n_err++;
      $display("FAIL div_zero: q=%h r=%0d dz=%b, required q=ff r=0 dz=1", quotient, remainder, div_zero);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int cyc;
    bit ok;
    accept(8'd100, 4'd9, ok);
    wait_done(cyc);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      dividend = 8'd3;
      divisor  = 4'd2;
      tick();
      n_cmp++;
      if ({out_valid, in_ready, quotient, remainder, div_zero} !== {1'b1, 1'b0, 8'd11, 4'd1, 1'b0}) begin
        n_err++;
        $display("FAIL backpressure cyc%0d: ov=%b ir=%b q=%0d r=%0d dz=%b, required 1 0 11 1 0",
                 i, out_valid, in_ready, quotient, remainder, div_zero);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_abort();
    int cyc;
    bit ok;
    accept(8'd200, 4'd7, ok);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, quotient, remainder, div_zero} !== {1'b1, 1'b0, 8'd0, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_abort: ir=%b ov=%b q=%0d r=%0d dz=%b, required 1 0 0 0 0",
               in_ready, out_valid, quotient, remainder, div_zero);
    end
    accept(8'd77, 4'd6, ok);
    wait_done(cyc);
    n_cmp++;
    if (!ok || cyc !== 8 || {quotient, remainder} !== {8'd12, 4'd5}) begin
      n_err++;
      $display("FAIL after_abort 77/6: q=%0d r=%0d cycles=%0d, required q=12 r=5 cycles=8",
               quotient, remainder, cyc);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit ok;
    int prod;
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        accept(8'(a), 4'(b), ok);
        wait_done(cyc);
        repeat ($urandom_range(0, 2)) tick();
        prod = int'(quotient) * b + int'(remainder);
        n_cmp++;
        if (!ok || !out_valid || prod != a || int'(remainder) >= b || div_zero !== 1'b0) begin
          n_err++;
          $display("FAIL exhaustive %0d/%0d: q=%0d r=%0d dz=%b ov=%b, required q*d+r=%0d r<%0d",
                   a, b, quotient, remainder, div_zero, out_valid, a, b);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
